drive_ctrl_seq: RTL
===================

// Module: drive_ctrl_seq
// PURPOSE
//  Parametrised, registered drive control core for the floppy bus interface. Synchronises
//  bus and sensor inputs and runs a stepper FSM with step queueing and track-limit handling.
//  Adds spindle spin-up qualification of READY and a selectable pin-34 mode (READY / DISK CHANGE).
//  Sits between the 34-pin bus and the motor/sensor hardware; trk_count feeds the data-path blocks.
// PARAMETERS
//  DRIVE_NUM     1      drive_sel bit that selects this drive (active-low)
//  SEL_W         4      width of drive_sel
//  NUM_TRACKS    80     track count, <=128; max track = NUM_TRACKS-1
//  STEP_SETTLE   3000   clk cycles coils are held after a phase change before the next step
//  SPINUP_CYC    500000 clk cycles from spin_en rise until spindle counts as at speed
//  PIN34_MODE    0      0: pin 34 = READY; 1: pin 34 = DISK CHANGE (PC style)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  dens_sel   in   1      bus density select (1 = 360 rpm)
//  in_use     in   1      bus in-use/head load, active-low
//  drive_sel  in   SEL_W  bus drive selects, active-low
//  motor_on   in   1      bus motor on, active-low
//  dir_sel    in   1      bus direction: 0 = inward (track+1), 1 = outward (track-1)
//  step       in   1      bus step pulse, active-low; action on falling edge
//  ind_sens   in   1      index sensor, 0 = hole present
//  t00_sens   in   1      track-0 sensor, 1 = at track 0
//  wpr_sens   in   1      write-protect sensor, 1 = protected
//  dsk_sens   in   1      disk sensor, 1 = disk present
//  index      out  1      bus index, active-low
//  track_0    out  1      bus track 00, active-low
//  wr_protect out  1      bus write protect, active-low
//  ready      out  1      bus pin 34 (READY or DISK CHANGE per PIN34_MODE), active-low
//  spin_en    out  1      spindle motor enable
//  spin_ss    out  1      spindle speed select
//  step_drv   out  4      stepper coil drive (ULN2003)
//  head_load  out  1      head-load solenoid
//  front_LED  out  1      front panel LED
//  step_busy  out  1      stepper FSM not IDLE
//  trk_count  out  7      current track number
// BEHAVIOUR
//  - All inputs pass through 2-flop synchronisers; every output is registered. Input to
//    output latency is 3 clk. sel = ~drive_sel_s[DRIVE_NUM].
//  - Reset values: index/track_0/wr_protect/ready = 1, spin_en/spin_ss/head_load/front_LED = 0,
//    step_busy = 0, step_drv = 4'b0001 (phase 0), trk_count = 0, spin counter = 0, chg latch = 1.
//    A reset mid-step aborts the FSM and drops any queued step.
//  - Bus outputs: index = ~(~ind_s & sel); track_0 = ~(t00_s & sel); wr_protect = ~(wpr_s & sel).
//  - Step edge: step_s 1->0 with sel = 1; dir_s is sampled on the same cycle.
//  - Stepper FSM IDLE -> MOVE (1 clk) -> SETTLE (STEP_SETTLE clk) -> IDLE.
//    Edge in IDLE: start. Edge in MOVE/SETTLE: queue into a 1-deep pending slot; further edges
//    are dropped. A pending step starts on the cycle SETTLE ends.
//  - In MOVE: inward moves phase +1 mod 4 and trk_count +1; outward moves phase -1 mod 4 and
//    trk_count -1. The phase sequence is 0001,0010,0100,1000. Coils stay energised on the last phase.
//  - Inward at trk_count = NUM_TRACKS-1: the step is ignored (no phase change, no SETTLE).
//  - Outward with t00_s = 1: ignored. Outward at trk_count = 0 with t00_s = 0: phase moves and
//    trk_count stays 0 (recalibrate seek).
//  - trk_count is forced to 0 whenever t00_s = 1 and the FSM is IDLE.
//  - spin_en = ~motor_on_s, independent of sel. spin_ss = dens_s.
//  - Spin counter clears while spin_en = 0 and counts up while spin_en = 1, saturating at
//    SPINUP_CYC. at_speed = (count == SPINUP_CYC). Motor off clears at_speed on the next clk.
//  - chg latch: set on reset and on dsk_s 1->0. Cleared by a step edge while sel & dsk_s,
//    including a step edge that is ignored.
//  - PIN34_MODE 0: ready = ~(sel & at_speed & dsk_s). PIN34_MODE 1: ready = ~(sel & chg).
//  - head_load = sel & ~in_use_s & dsk_s. front_LED = spin_en | head_load.
// TESTING
//  - rst 1 clk -> step_drv = 0001, trk_count = 0, all bus outputs 1, chg = 1, step_busy = 0.
//  - sel, dsk = 1, t00 = 0, dir = 0, 3 step pulses spaced > STEP_SETTLE -> step_drv 0010, 0100,
//    1000 and trk_count = 3.
//  - Two step edges 10 clk apart, then a third 20 clk later, all inward -> trk_count +2 only;
//    the second step's MOVE occurs exactly STEP_SETTLE+1 clk after the first.
//  - trk_count = 79, inward step -> trk_count stays 79 and step_drv unchanged. Outward step with
//    t00 = 1 -> ignored and trk_count = 0.
//  - PIN34_MODE 0, motor_on 1->0 -> ready stays 1 until SPINUP_CYC+3 clk, then 0.
//    motor_on -> 1 -> ready = 1 within 4 clk.
//  - PIN34_MODE 1, dsk_sens 1->0->1 -> ready = 0. Next step edge while selected -> ready = 1 after 1-2 clk.

Source files
------------

// File: rtl/drive_ctrl_seq.sv
// Floppy drive control core: input synchronisers, stepper FSM with a 1-deep step queue,
// track-limit handling, spindle spin-up qualification and selectable pin-34 behaviour.
module drive_ctrl_seq #(
  parameter int DRIVE_NUM   = 1,
  parameter int SEL_W       = 4,
  parameter int NUM_TRACKS  = 80,
  parameter int STEP_SETTLE = 3000,
  parameter int SPINUP_CYC  = 500000,
  parameter int PIN34_MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dens_sel,
  input  logic             in_use,
  input  logic [SEL_W-1:0] drive_sel,
  input  logic             motor_on,
  input  logic             dir_sel,
  input  logic             step,
  input  logic             ind_sens,
  input  logic             t00_sens,
  input  logic             wpr_sens,
  input  logic             dsk_sens,
  output logic             index,
  output logic             track_0,
  output logic             wr_protect,
  output logic             ready,
  output logic             spin_en,
  output logic             spin_ss,
  output logic [3:0]       step_drv,
  output logic             head_load,
  output logic             front_LED,
  output logic             step_busy,
  output logic [6:0]       trk_count
);

  localparam int IN_W = SEL_W + 9;
  localparam int SC_W = (STEP_SETTLE > 1) ? $clog2(STEP_SETTLE + 1) : 1;
  localparam int SP_W = $clog2(SPINUP_CYC + 1);
  localparam logic [6:0] TRK_MAX = 7'(NUM_TRACKS - 1);
  // Synchronisers reset to the bus-idle level so no spurious edges appear after reset
  localparam logic [IN_W-1:0] SYNC_RST = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                          {SEL_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  logic [IN_W-1:0]  sync1_d, sync1_q, sync_q;
  logic             dens_s, in_use_s, motor_on_s, dir_s, step_s, ind_s, t00_s, wpr_s, dsk_s;
  logic [SEL_W-1:0] drive_sel_s;
  logic             sel, step_edge, dsk_fall, at_speed;

  state_t           state_d, state_q;
  logic [SC_W-1:0]  cnt_d, cnt_q;
  logic             pend_d, pend_q, pdir_d, pdir_q, dir_d, dir_q;
  logic [3:0]       phase_d, phase_q;
  logic [6:0]       trk_d, trk_q;
  logic [SP_W-1:0]  spin_cnt_d, spin_cnt_q;
  logic             chg_d, chg_q, step_prev_q, dsk_prev_q;
  logic             index_d, track_0_d, wr_protect_d, ready_d, spin_en_d, spin_ss_d;
  logic             head_load_d, front_led_d, step_busy_d;
  logic             index_q, track_0_q, wr_protect_q, ready_q, spin_en_q, spin_ss_q;
  logic             head_load_q, front_led_q, step_busy_q;

  assign {dens_s, in_use_s, motor_on_s, dir_s, step_s, ind_s, t00_s, wpr_s, dsk_s,
          drive_sel_s} = sync_q;

  always_comb begin
    sync1_d   = {dens_sel, in_use, motor_on, dir_sel, step, ind_sens, t00_sens, wpr_sens,
                 dsk_sens, drive_sel};
    sel       = ~drive_sel_s[DRIVE_NUM];
    step_edge = step_prev_q & ~step_s & sel;
    dsk_fall  = dsk_prev_q & ~dsk_s;

    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pdir_d  = pdir_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    trk_d   = trk_q;

    if (state_q != IDLE && step_edge && !pend_q) begin
      pend_d = 1'b1;
      pdir_d = dir_s;
    end

    case (state_q)
      IDLE: begin
        // A leftover pending step (after an ignored move) takes precedence over a new edge
        if (pend_q) begin
          state_d = MOVE;
          dir_d   = pdir_q;
          pend_d  = step_edge;
          pdir_d  = dir_s;
        end else if (step_edge) begin
          state_d = MOVE;
          dir_d   = dir_s;
        end
      end
      MOVE: begin
        if (!dir_q && trk_q != TRK_MAX) begin
          phase_d = {phase_q[2:0], phase_q[3]};
          trk_d   = trk_q + 7'd1;
          state_d = SETTLE;
          cnt_d   = SC_W'(STEP_SETTLE - 1);
        end else if (dir_q && !t00_s) begin
          phase_d = {phase_q[0], phase_q[3:1]};
          if (trk_q != 7'd0) trk_d = trk_q - 7'd1;
          state_d = SETTLE;
          cnt_d   = SC_W'(STEP_SETTLE - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          if (pend_q || step_edge) begin
            state_d = MOVE;
            dir_d   = pend_q ? pdir_q : dir_s;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - SC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && t00_s) trk_d = 7'd0;

    spin_en_d  = ~motor_on_s;
    spin_ss_d  = dens_s;
    at_speed   = (spin_cnt_q == SP_W'(SPINUP_CYC));
    if (!spin_en_d)    spin_cnt_d = '0;
    else if (at_speed) spin_cnt_d = spin_cnt_q;
    else               spin_cnt_d = spin_cnt_q + SP_W'(1);

    chg_d = chg_q;
    if (step_edge && dsk_s) chg_d = 1'b0;
    if (dsk_fall)           chg_d = 1'b1;

    index_d      = ~(~ind_s & sel);
    track_0_d    = ~(t00_s & sel);
    wr_protect_d = ~(wpr_s & sel);
    ready_d      = (PIN34_MODE != 0) ? ~(sel & chg_q) : ~(sel & at_speed & dsk_s);
    head_load_d  = sel & ~in_use_s & dsk_s;
    front_led_d  = spin_en_d | head_load_d;
    step_busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= SYNC_RST;
      sync_q       <= SYNC_RST;
      step_prev_q  <= 1'b1;
      dsk_prev_q   <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pdir_q       <= 1'b0;
      dir_q        <= 1'b0;
      phase_q      <= 4'b0001;
      trk_q        <= 7'd0;
      spin_cnt_q   <= '0;
      chg_q        <= 1'b1;
      index_q      <= 1'b1;
      track_0_q    <= 1'b1;
      wr_protect_q <= 1'b1;
      ready_q      <= 1'b1;
      spin_en_q    <= 1'b0;
      spin_ss_q    <= 1'b0;
      head_load_q  <= 1'b0;
      front_led_q  <= 1'b0;
      step_busy_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync_q       <= sync1_q;
      step_prev_q  <= step_s;
      dsk_prev_q   <= dsk_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pdir_q       <= pdir_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      trk_q        <= trk_d;
      spin_cnt_q   <= spin_cnt_d;
      chg_q        <= chg_d;
      index_q      <= index_d;
      track_0_q    <= track_0_d;
      wr_protect_q <= wr_protect_d;
      ready_q      <= ready_d;
      spin_en_q    <= spin_en_d;
      spin_ss_q    <= spin_ss_d;
      head_load_q  <= head_load_d;
      front_led_q  <= front_led_d;
      step_busy_q  <= step_busy_d;
    end
  end

  assign index      = index_q;
  assign track_0    = track_0_q;
  assign wr_protect = wr_protect_q;
  assign ready      = ready_q;
  assign spin_en    = spin_en_q;
  assign spin_ss    = spin_ss_q;
  assign step_drv   = phase_q;
  assign head_load  = head_load_q;
  assign front_LED  = front_led_q;
  assign step_busy  = step_busy_q;
  assign trk_count  = trk_q;

endmodule
